// File: rtl/oled_text_arbiter.sv
// Merges per-source AXI-Stream line updates into a four-line OLED text frame and
// offers whole-frame snapshots to the display wrapper, spaced by a hold-off window.
module oled_text_arbiter #(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned HOLDOFF_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [128*NUM_SRC-1:0]   s_axis_tdata,
  input  logic [2*NUM_SRC-1:0]     s_axis_tdest,
  input  logic [NUM_SRC-1:0]       s_axis_tvalid,
  output logic [NUM_SRC-1:0]       s_axis_tready,
  output logic [127:0]             m_axis_tdata_str1,
  output logic [127:0]             m_axis_tdata_str2,
  output logic [127:0]             m_axis_tdata_str3,
  output logic [127:0]             m_axis_tdata_str4,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     dirty,
  output logic [7:0]               frame_count
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StOffer = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic [1:0]         r_state;
  logic [HW-1:0]      r_hold_cnt;
  logic [1:0]         r_rr;
  logic               r_dirty;
  logic [7:0]         r_frame_count;
  logic [127:0]       r_line [4];
  logic [127:0]       r_str  [4];

  logic [3:0]         w_valid4;
  logic [1:0]         w_idx;
  logic               w_gnt_vld;
  logic [1:0]         w_gnt_idx;
  logic [1:0]         w_rr_next;
  logic               w_accept;
  logic [1:0]         w_dest;
  logic [127:0]       w_data;
  logic [NUM_SRC-1:0] w_ready;

  // Padding to four bits keeps the 2-bit index legal for any NUM_SRC in 2..4.
  assign w_valid4 = 4'(s_axis_tvalid);

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_idx = 2'((32'(r_rr) + k) % NUM_SRC);
      if (!w_gnt_vld && w_valid4[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_dest  = '0;
    w_data  = '0;
    w_ready = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (w_gnt_vld && (w_gnt_idx == 2'(i))) begin
        w_dest     = s_axis_tdest[2*i +: 2];
        w_data     = s_axis_tdata[128*i +: 128];
        w_ready[i] = !reset;
      end
    end
  end

  assign w_accept  = w_gnt_vld && !reset;
  assign w_rr_next = ((32'(w_gnt_idx) + 32'd1) == NUM_SRC) ? 2'd0 : w_gnt_idx + 2'd1;

  assign s_axis_tready     = w_ready;
  assign m_axis_tvalid     = (r_state == StOffer) && !reset;
  assign m_axis_tdata_str1 = r_str[0];
  assign m_axis_tdata_str2 = r_str[1];
  assign m_axis_tdata_str3 = r_str[2];
  assign m_axis_tdata_str4 = r_str[3];
  assign dirty             = r_dirty;
  assign frame_count       = r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_hold_cnt    <= '0;
      r_rr          <= '0;
      r_dirty       <= 1'b0;
      r_frame_count <= '0;
      for (int i = 0; i < 4; i++) begin
        r_line[i] <= '0;
        r_str[i]  <= '0;
      end
    end else begin
      if (w_accept) begin
        r_line[w_dest] <= w_data;
        r_rr           <= w_rr_next;
      end
      // A beat landing on the snapshot edge keeps dirty set for the next frame.
      if (w_accept) begin
        r_dirty <= 1'b1;
      end else if ((r_state == StIdle) && r_dirty) begin
        r_dirty <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (r_dirty) begin
            r_state <= StOffer;
            for (int i = 0; i < 4; i++) r_str[i] <= r_line[i];
          end
        end
        StOffer: begin
          if (m_axis_tready) begin
            r_state       <= StHold;
            r_hold_cnt    <= HW'(HOLDOFF_CYCLES - 1);
            r_frame_count <= r_frame_count + 8'd1;
          end
        end
        StHold: begin
          if (r_hold_cnt == '0) r_state <= StIdle;
          else                  r_hold_cnt <= r_hold_cnt - HW'(1);
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_arbiter.sv
// Directed bench for oled_text_arbiter; expected frames are queued when beats are driven
// and checked against the outputs at each frame handshake.
module tb_oled_text_arbiter;

  localparam int unsigned NS = 3;
  localparam int unsigned HO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [128*NS-1:0] s_axis_tdata;
  logic [2*NS-1:0]   s_axis_tdest;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tready;
  logic [127:0]      str1, str2, str3, str4;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              dirty;
  logic [7:0]        frame_count;

  always #5 clk = ~clk;

  oled_text_arbiter #(
    .NUM_SRC        (NS),
    .HOLDOFF_CYCLES (HO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tdest      (s_axis_tdest),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata_str1 (str1),
    .m_axis_tdata_str2 (str2),
    .m_axis_tdata_str3 (str3),
    .m_axis_tdata_str4 (str4),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .dirty             (dirty),
    .frame_count       (frame_count)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  int           n_hs  = 0;
  logic [511:0] sb_q[$];
  logic [511:0] sb_exp;
  logic [511:0] frame_a;
  logic [127:0] mline [4];
  logic [1:0]   dest_of [3];
  logic [127:0] beat;
  wire  [511:0] w_out = {str4, str3, str2, str1};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mframe();
    return {mline[3], mline[2], mline[1], mline[0]};
  endfunction

  // Scoreboard: every frame handshake pops the oldest expected snapshot.
  always @(negedge clk) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 512'(sb_q.size()), 512'd1);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("frame", w_out, sb_exp);
      end
      n_hs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [1:0] d, input logic [127:0] data);
    s_axis_tdata[128*i +: 128] = data;
    s_axis_tdest[2*i +: 2]     = d;
    s_axis_tvalid[i]           = 1'b1;
    #1;
  endtask

  task automatic send(input int i, input logic [1:0] d, input logic [127:0] data);
    set_src(i, d, data);
    tick();
    s_axis_tvalid = '0;
    mline[d] = data;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (n_hs < target && k < budget) begin
      tick();
      k++;
    end
    chk("hs_timeout", 512'(n_hs >= target), 512'd1);
  endtask

  initial begin
    dest_of[0] = 2'd0;
    dest_of[1] = 2'd1;
    dest_of[2] = 2'd3;
    for (int i = 0; i < 4; i++) mline[i] = '0;
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tdest  = '0;
    s_axis_tvalid = '1;
    m_axis_tready = 1'b0;

    // Reset state, with every source requesting.
    tick();
    chk("rst_ready", 512'(s_axis_tready), 512'd0);
    chk("rst_tvalid", 512'(m_axis_tvalid), 512'd0);
    tick();
    chk("rst_str", w_out, 512'd0);
    chk("rst_fc", 512'(frame_count), 512'd0);
    chk("rst_dirty", 512'(dirty), 512'd0);
    s_axis_tvalid = '0;
    reset         = 1'b0;
    tick();

    // Single update: line 2 from source 0.
    set_src(0, 2'd2, {16{8'h41}});
    chk("t1_ready", 512'(s_axis_tready), 512'd1);
    tick();
    s_axis_tvalid = '0;
    mline[2] = {16{8'h41}};
    chk("t1_dirty", 512'(dirty), 512'd1);
    chk("t1_tvalid_early", 512'(m_axis_tvalid), 512'd0);
    sb_q.push_back(mframe());
    tick();
    chk("t1_tvalid", 512'(m_axis_tvalid), 512'd1);
    chk("t1_str", w_out, mframe());
    m_axis_tready = 1'b1;
    wait_hs(1, 5);
    chk("t1_fc", 512'(frame_count), 512'd1);
    chk("t1_dirty_clr", 512'(dirty), 512'd0);
    repeat (20) tick();

    // One beat from source 2 returns the pointer to 0.
    send(2, 2'd3, {16{8'hC3}});
    sb_q.push_back(mframe());
    wait_hs(2, 5);
    repeat (20) tick();

    // Round-robin with all sources valid; the first beat precedes the snapshot, the
    // second lands on the snapshot edge and must wait for the next frame.
    m_axis_tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < 3; s++) set_src(s, dest_of[s], {16{8'(16 * s + c)}});
      chk("t2_grant", 512'(s_axis_tready), 512'(3'b001 << (c % 3)));
      tick();
      mline[dest_of[c % 3]] = {16{8'(16 * (c % 3) + c)}};
      if (c == 0) sb_q.push_back(mframe());
      if (c == 1) begin
        chk("t5_tvalid", 512'(m_axis_tvalid), 512'd1);
        chk("t5_dirty", 512'(dirty), 512'd1);
      end
    end
    s_axis_tvalid = '0;
    chk("t2_dirty", 512'(dirty), 512'd1);
    chk("t2_snap_stable", w_out, sb_q[0]);
    sb_q.push_back(mframe());
    m_axis_tready = 1'b1;
    wait_hs(4, 40);
    repeat (20) tick();

    // Hold-off: one update every 3 cycles with the display always ready.
    for (int c = 0; c <= 60; c++) begin
      if (c % 3 == 0 && c <= 54) set_src(1, 2'(c / 3), {16{8'(c)}});
      tick();
      if (c % 3 == 0 && c <= 54) begin
        mline[2'(c / 3)] = {16{8'(c)}};
        if (c % 18 == 0) sb_q.push_back(mframe());
      end
      s_axis_tvalid = '0;
      chk("t3_tvalid", 512'(m_axis_tvalid), 512'((c % 18 == 1) && (c <= 55)));
    end
    wait_hs(8, 5);
    repeat (20) tick();

    // Back-pressure: the offered snapshot stays put while every line is rewritten.
    m_axis_tready = 1'b0;
    send(0, 2'd0, {16{8'hA5}});
    sb_q.push_back(mframe());
    frame_a = mframe();
    tick();
    chk("t4_tvalid", 512'(m_axis_tvalid), 512'd1);
    for (int c = 0; c < 20; c++) begin
      beat = {16{8'(8'hB0 + c)}};
      set_src(c % 3, 2'(c % 4), beat);
      tick();
      s_axis_tvalid = '0;
      mline[2'(c % 4)] = beat;
      chk("t4_str", w_out, frame_a);
      chk("t4_dirty", 512'(dirty), 512'd1);
      chk("t4_tvalid_hold", 512'(m_axis_tvalid), 512'd1);
    end
    sb_q.push_back(mframe());
    m_axis_tready = 1'b1;
    wait_hs(10, 40);
    repeat (20) tick();

    // Reset in the middle of an offer drops it.
    m_axis_tready = 1'b0;
    send(1, 2'd1, {16{8'h66}});
    tick();
    chk("t6_tvalid", 512'(m_axis_tvalid), 512'd1);
    reset = 1'b1;
    for (int s = 0; s < 3; s++) set_src(s, 2'(s), {16{8'(8'h70 + s)}});
    chk("t6_rst_tvalid", 512'(m_axis_tvalid), 512'd0);
    chk("t6_rst_ready", 512'(s_axis_tready), 512'd0);
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) mline[i] = '0;
    chk("t6_str", w_out, 512'd0);
    chk("t6_fc", 512'(frame_count), 512'd0);
    chk("t6_dirty", 512'(dirty), 512'd0);
    chk("t6_tvalid_after", 512'(m_axis_tvalid), 512'd0);
    chk("t6_rr", 512'(s_axis_tready), 512'd1);
    tick();
    s_axis_tvalid = '0;
    mline[0] = {16{8'h70}};
    sb_q.push_back(mframe());
    m_axis_tready = 1'b1;
    wait_hs(11, 10);
    chk("t6_fc_resume", 512'(frame_count), 512'd1);
    chk("sb_empty", 512'(sb_q.size()), 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oled_text_arbiter.md
# oled_text_arbiter

Shares the four-line, 128-bit-per-line OLED text frame between several AXI-Stream text producers. It merges their line updates into one working frame buffer and schedules whole-frame transfers to the OLED display wrapper. Transfers use a valid/ready handshake, with a minimum hold-off between frames so the display driver is never flooded. It sits between the producers (status monitors, debug counters, software bridge) and the `m_axis_tdata_str1..4` / `m_axis_tvalid` inputs of the display wrapper.

## Interface
Parameters:
- `NUM_SRC`, default 3: number of requesters, legal range 2..4.
- `HOLDOFF_CYCLES`, default 16: minimum number of cycles from a frame handshake to the next frame offer; must be ≥ 1.

Ports:
- `clk`  in  1  the only clock; all logic on the rising edge.
- `reset`  in  1  synchronous reset, active high.
- `s_axis_tdata`  in  128·NUM_SRC  line text per source. Source i occupies bits [128i+127:128i].
- `s_axis_tdest`  in  2·NUM_SRC  target line per source: 0→str1 … 3→str4.
- `s_axis_tvalid`  in  NUM_SRC  per-source valid.
- `s_axis_tready`  out  NUM_SRC  per-source ready; at most one bit is high per cycle.
- `m_axis_tdata_str1..str4`  out  128 each  frame snapshot sent to the display wrapper.
- `m_axis_tvalid`  out  1  frame offer.
- `m_axis_tready`  in  1  display wrapper accepts the frame.
- `dirty`  out  1  the working buffer holds updates not yet offered.
- `frame_count`  out  8  number of completed frame handshakes; wraps from 255 to 0.

## Operation
- **Working buffer.** Four 128-bit line registers, `line[0..3]`.
- **Arbitration.** Round-robin pointer `rr`, reset value 0.
  - Each cycle the grant goes to the first index i with `s_axis_tvalid[i]=1`, scanning rr, rr+1, … mod NUM_SRC.
  - `s_axis_tready[grant]=1` combinationally; all other ready bits are 0.
  - If no source is valid, there is no grant, all ready bits are 0, and `rr` is unchanged.
- **Accept.** An accepted beat (valid & ready) writes `line[tdest]` and sets `dirty` at that edge, and sets `rr` to (grant+1) mod NUM_SRC.
- **Acceptance continues in every scheduler state.** Producers are never blocked by the display.
- **Scheduler states:**
  - **IDLE**
    - `m_axis_tvalid=0`.
    - If `dirty=1` → OFFER. On that edge, snapshot `line[0..3]` into `m_axis_tdata_str1..4`, as the values held before the edge.
    - On that edge `dirty` clears, unless a beat is accepted on the same edge; then `dirty` stays 1 and that beat waits for the next frame.
  - **OFFER**
    - `m_axis_tvalid=1`. Snapshot outputs are held stable.
    - On `m_axis_tready=1`: go to HOLD, load `hold_cnt` with HOLDOFF_CYCLES−1, and increment `frame_count`.
  - **HOLD**
    - `m_axis_tvalid=0`.
    - If `hold_cnt=0` → IDLE; otherwise decrement `hold_cnt`.
    - Snapshot outputs keep their last value.
- **Duplicate writes.** Several writes to the same line before a snapshot leave only the last value visible.
- **Reset.** Reset overrides everything, including mid-OFFER or mid-HOLD.
  - State → IDLE; `hold_cnt`, `rr`, `dirty`, `frame_count` → 0.
  - `line[0..3]` and `m_axis_tdata_str1..4` → 0.
  - `m_axis_tvalid`=0 and `s_axis_tready`=0 while reset is high.
  - An in-flight offer is dropped and not counted.

## Timing
- **Input latency.** A beat accepted at edge N is visible in `line[]` and `dirty` after edge N.
- **Offer latency.** From IDLE, `m_axis_tvalid` rises after edge N+1. The best case is 2 cycles from `s_axis_tvalid` to `m_axis_tvalid`.
- **Frame spacing.** Handshake at edge H → next `m_axis_tvalid` no earlier than after edge H+HOLDOFF_CYCLES+1 (HOLD, then IDLE, then OFFER). This applies only if `dirty` was set by then.
- **Arbitration.** One beat is accepted per cycle in total. Each valid source is served within NUM_SRC cycles.
- **Back-to-back handshake.** `m_axis_tready` held high gives a 1-cycle OFFER.

## Test plan
1. **Single update.** Reset, then source 0 sends tdest=2, data 0x41..41.
   - Expect `m_axis_tvalid` after 2 cycles, str3=0x41..41, others 0.
   - Handshake → `frame_count`=1, `dirty`=0.
2. **Round-robin fairness.** All 3 sources hold valid for 6 cycles, each with a distinct tdest and data.
   - Expect the grant order 0,1,2,0,1,2.
   - Exactly one ready bit per cycle; the final line contents match the last beat per tdest.
3. **Hold-off.** HOLDOFF_CYCLES=16, `m_axis_tready`=1, one update every 3 cycles.
   - Expect consecutive `m_axis_tvalid` rises spaced exactly 18 cycles.
   - The snapshot contains the latest lines each time.
4. **Back-pressure stability.** `m_axis_tready`=0 for 20 cycles during OFFER while sources write all lines.
   - Expect str1..4 unchanged, `dirty`=1 throughout, and a second frame with the new data after the handshake and hold-off.
5. **Simultaneous accept and snapshot.** Beat accepted on the IDLE→OFFER edge.
   - Expect that beat excluded from the current snapshot, `dirty`=1, and the beat present in the following frame.
6. **Reset mid-OFFER.** Assert reset for 1 cycle while `m_axis_tvalid`=1.
   - Expect `m_axis_tvalid`=0, all str outputs 0, `frame_count` 0, and `rr`=0 on the next cycle.
   - Normal operation resumes afterwards.
